conv_mac_multich: RTL and testbench

Multi-channel signed convolution MAC: each input beat carries one KERNEL×KERNEL data window and its matching weight window for one input channel. The block computes the beat's dot product in a pipelined adder tree and accumulates C_IN consecutive beats into one output pixel. It then rescales, optionally rectifies, and saturates the result. It sits downstream of the window generator and replaces the single-channel ConvLayer_calc datapath in multi-channel layers.

---
 rtl/conv_mac_multich.sv | 215 +++++++++++++++++++++
 tb/tb_conv_mac_multich.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mac_multich.sv
`default_nettype none
// ============================================================================
// Module   : conv_mac_multich
// Brief    : Multi-channel signed convolution MAC. Each beat carries one
//            KERNEL x KERNEL data window and its weight window for a single
//            input channel. The beat's dot product goes through a registered
//            product stage and a registered sum stage. C_IN consecutive beats
//            are accumulated into one output pixel. The pixel is then
//            arithmetically shifted, optionally rectified, and saturated.
// Options  : CONV_MAC_RELU_EN - when defined, a negative shifted result gives
//            d_out = 0 with sat = 0 (acc_out remains unrectified).
// Ports    : clk, rst        - clock and synchronous active-high reset
//            data2conv       - KK signed N-bit elements, element i at [i*N +: N]
//            w               - KK signed M-bit weights, element i at [i*M +: M]
//            en_in           - beat valid (no backpressure)
//            clr             - abandon the current pixel
//            acc_out         - full-precision pixel sum
//            d_out, sat      - shifted/saturated pixel and clip flag
//            en_out          - one-cycle pulse, pixel outputs valid
//            ch_idx          - channel index the next accepted beat will take
// Revision : 1.0 - initial release
// ============================================================================
module conv_mac_multich #(
    parameter int KERNEL = 3,
    parameter int N      = 4,
    parameter int M      = 4,
    parameter int C_IN   = 4,
    parameter int E      = 6,
    parameter int ACC_W  = N + M + E,
    parameter int OUT_W  = 8,
    parameter int SHIFT  = 0,
    localparam int CH_W  = (C_IN > 1) ? $clog2(C_IN) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [KERNEL*KERNEL*N-1:0]  data2conv,
    input  logic [KERNEL*KERNEL*M-1:0]  w,
    input  logic                        en_in,
    input  logic                        clr,
    output logic signed [ACC_W-1:0]     acc_out,
    output logic signed [OUT_W-1:0]     d_out,
    output logic                        sat,
    output logic                        en_out,
    output logic [CH_W-1:0]             ch_idx
);

    localparam int c_kk    = KERNEL * KERNEL;
    localparam int c_pw    = N + M;
    localparam int c_cnt_w = $clog2(C_IN + 1);
    localparam int c_ext_w = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_accum = 1'b1;

    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(C_IN);
    localparam logic [CH_W-1:0]    c_ch_last  = CH_W'(C_IN - 1);
    localparam logic [CH_W-1:0]    c_ch_first = CH_W'((C_IN > 1) ? 1 : 0);

    localparam logic signed [c_ext_w-1:0] c_sat_max =
        {{(c_ext_w - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [c_ext_w-1:0] c_sat_min =
        {{(c_ext_w - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

    // ------------------------------------------------------------------
    // Stage P: element-wise signed products
    // ------------------------------------------------------------------
    logic signed [c_pw-1:0] w_prod [c_kk];
    logic signed [c_pw-1:0] r_prod [c_kk];
    logic                   r_p_vld;

    generate
        for (genvar gi = 0; gi < c_kk; gi++) begin : g_prod
            logic signed [c_pw-1:0] w_a;
            logic signed [c_pw-1:0] w_b;
            // Both operands are widened to the product width so the
            // low c_pw bits of the multiply are the exact signed product.
            assign w_a = {{M{data2conv[gi*N+N-1]}}, data2conv[gi*N +: N]};
            assign w_b = {{N{w[gi*M+M-1]}}, w[gi*M +: M]};
            assign w_prod[gi] = w_a * w_b;
        end
    endgenerate

    always_ff @(posedge clk) begin
        r_prod <= w_prod;
    end

    // A beat presented during clr is still accepted as channel 0 of the
    // next pixel, so P loads en_in regardless of clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p_vld <= 1'b0;
        end else begin
            r_p_vld <= en_in;
        end
    end

    // ------------------------------------------------------------------
    // Stage T: sum of products, sign-extended to the accumulator width
    // ------------------------------------------------------------------
    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] r_sum;
    logic                    r_t_vld;

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < c_kk; i++) begin
            w_sum = w_sum + {{(ACC_W - c_pw){r_prod[i][c_pw-1]}}, r_prod[i]};
        end
    end

    always_ff @(posedge clk) begin
        r_sum <= w_sum;
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_t_vld <= 1'b0;
        end else begin
            r_t_vld <= r_p_vld;
        end
    end

    // ------------------------------------------------------------------
    // Stage A: channel accumulation controller
    // ------------------------------------------------------------------
    logic [0:0]              r_state;
    logic signed [ACC_W-1:0] r_acc;
    logic [c_cnt_w-1:0]      r_cnt;
    logic signed [ACC_W-1:0] w_acc_next;
    logic [c_cnt_w-1:0]      w_cnt_next;
    logic                    w_done;

    assign w_acc_next = (r_state == c_st_idle) ? r_sum : (r_acc + r_sum);
    assign w_cnt_next = (r_state == c_st_idle) ? c_cnt_w'(1) : (r_cnt + c_cnt_w'(1));
    assign w_done     = (w_cnt_next == c_cnt_last);

    // Rescale and saturate the completing pixel sum.
    logic signed [c_ext_w-1:0] w_ext;
    logic signed [c_ext_w-1:0] w_shift;
    logic signed [OUT_W-1:0]   w_d;
    logic                      w_sat;

    assign w_ext   = {{(c_ext_w - ACC_W){w_acc_next[ACC_W-1]}}, w_acc_next};
    assign w_shift = w_ext >>> SHIFT;

    always_comb begin
        w_d   = w_shift[OUT_W-1:0];
        w_sat = 1'b0;
`ifdef CONV_MAC_RELU_EN
        if (w_shift[c_ext_w-1]) begin
            w_d   = '0;
            w_sat = 1'b0;
        end else if (w_shift > c_sat_max) begin
            w_d   = c_sat_max[OUT_W-1:0];
            w_sat = 1'b1;
        end
`else
        if (w_shift > c_sat_max) begin
            w_d   = c_sat_max[OUT_W-1:0];
            w_sat = 1'b1;
        end else if (w_shift < c_sat_min) begin
            w_d   = c_sat_min[OUT_W-1:0];
            w_sat = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_state <= c_st_idle;
            r_acc   <= '0;
            r_cnt   <= '0;
            acc_out <= '0;
            d_out   <= '0;
            sat     <= 1'b0;
            en_out  <= 1'b0;
        end else begin
            en_out <= 1'b0;
            if (r_t_vld) begin
                if (w_done) begin
                    r_state <= c_st_idle;
                    r_acc   <= '0;
                    r_cnt   <= '0;
                    acc_out <= w_acc_next;
                    d_out   <= w_d;
                    sat     <= w_sat;
                    en_out  <= 1'b1;
                end else begin
                    r_state <= c_st_accum;
                    r_acc   <= w_acc_next;
                    r_cnt   <= w_cnt_next;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Input-side channel index: counts accepted beats modulo C_IN
    // ------------------------------------------------------------------
    logic [CH_W-1:0] w_ch_inc;

    assign w_ch_inc = (ch_idx == c_ch_last) ? '0 : (ch_idx + CH_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            ch_idx <= '0;
        end else if (clr) begin
            ch_idx <= en_in ? c_ch_first : '0;
        end else if (en_in) begin
            ch_idx <= w_ch_inc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_mac_multich.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_mac_multich
// Brief    : Self-checking bench for conv_mac_multich at default parameters.
//            Table of uniform-window pixels, hand sequences for gaps, clr and
//            rst, then randomized traffic against a pixel-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_mac_multich;

    localparam int KERNEL = 3;
    localparam int KK     = KERNEL * KERNEL;
    localparam int N      = 4;
    localparam int M      = 4;
    localparam int C_IN   = 4;
    localparam int E      = 6;
    localparam int ACC_W  = N + M + E;
    localparam int OUT_W  = 8;
    localparam int SHIFT  = 0;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [KK*N-1:0]         data2conv;
    logic [KK*M-1:0]         w;
    logic                    en_in;
    logic                    clr;
    logic signed [ACC_W-1:0] acc_out;
    logic signed [OUT_W-1:0] d_out;
    logic                    sat;
    logic                    en_out;
    logic [1:0]              ch_idx;

    conv_mac_multich #(
        .KERNEL (KERNEL),
        .N      (N),
        .M      (M),
        .C_IN   (C_IN),
        .E      (E),
        .ACC_W  (ACC_W),
        .OUT_W  (OUT_W),
        .SHIFT  (SHIFT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data2conv (data2conv),
        .w         (w),
        .en_in     (en_in),
        .clr       (clr),
        .acc_out   (acc_out),
        .d_out     (d_out),
        .sat       (sat),
        .en_out    (en_out),
        .ch_idx    (ch_idx)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        int due;
        int acc;
    } emit_t;

    emit_t q[$];
    int    e        = 0;
    int    part     = 0;
    int    cnt      = 0;
    int    cur_dot  = 0;
    int    last_acc = 0;
    int    last_d   = 0;
    int    last_sat = 0;
    int    d_arr [KK];
    int    w_arr [KK];

    int    n_vec = 0;
    int    n_err = 0;
    int    pulses = 0;
    int    cap_acc = 0;
    int    cap_d   = 0;
    int    cap_sat = 0;

    function automatic void ref_out(input int acc, output int d, output int s);
        int sh;
        int hi;
        int lo;
        sh = acc >>> SHIFT;
        hi = (1 << (OUT_W - 1)) - 1;
        lo = -(1 << (OUT_W - 1));
        d  = sh;
        s  = 0;
`ifdef CONV_MAC_RELU_EN
        if (sh < 0) begin
            d = 0;
        end else if (sh > hi) begin
            d = hi;
            s = 1;
        end
`else
        if (sh > hi) begin
            d = hi;
            s = 1;
        end else if (sh < lo) begin
            d = lo;
            s = 1;
        end
`endif
    endfunction

    task automatic cmp(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, e);
        end
    endtask

    task automatic pack();
        cur_dot = 0;
        for (int i = 0; i < KK; i++) begin
            data2conv[i*N +: N] = d_arr[i][N-1:0];
            w[i*M +: M]         = w_arr[i][M-1:0];
            cur_dot += d_arr[i] * w_arr[i];
        end
    endtask

    task automatic set_all(input int dv, input int wv);
        for (int i = 0; i < KK; i++) begin
            d_arr[i] = dv;
            w_arr[i] = wv;
        end
        pack();
    endtask

    task automatic set_rand();
        for (int i = 0; i < KK; i++) begin
            d_arr[i] = int'($urandom_range(15)) - 8;
            w_arr[i] = int'($urandom_range(15)) - 8;
        end
        pack();
    endtask

    task automatic model_update();
        if (rst) begin
            q.delete();
            part = 0;
            cnt  = 0;
            last_acc = 0;
            last_d   = 0;
            last_sat = 0;
        end else begin
            if (clr) begin
                // pixels still in flight are lost, as is the partial sum
                while (q.size() > 0 && q[$].due >= e) void'(q.pop_back());
                part = 0;
                cnt  = 0;
                last_acc = 0;
                last_d   = 0;
                last_sat = 0;
            end
            if (en_in) begin
                part += cur_dot;
                cnt++;
                if (cnt == C_IN) begin
                    q.push_back('{due: e + 2, acc: part});
                    part = 0;
                    cnt  = 0;
                end
            end
        end
    endtask

    task automatic check();
        int exp_en;
        exp_en = 0;
        if (q.size() > 0 && q[0].due == e) begin
            emit_t it;
            it = q.pop_front();
            exp_en   = 1;
            last_acc = it.acc;
            ref_out(it.acc, last_d, last_sat);
        end
        cmp("en_out", int'(en_out), exp_en);
        cmp("acc_out", int'(acc_out), last_acc);
        cmp("d_out", int'(d_out), last_d);
        cmp("sat", int'(sat), last_sat);
        cmp("ch_idx", int'(ch_idx), cnt);
        if (en_out) begin
            pulses++;
            cap_acc = int'(acc_out);
            cap_d   = int'(d_out);
            cap_sat = int'(sat);
        end
    endtask

    task automatic step();
        @(posedge clk);
        e++;
        model_update();
        #1;
        check();
    endtask

    task automatic idle(input int n);
        en_in = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        int dval;
        int wval;
        int acc;
        int d;
        int sat;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int p0;
        int exp_d;
        int exp_s;

        tbl[0] = '{dval:  1, wval:  1, acc:    36, d:   36, sat: 0};
        tbl[1] = '{dval: -8, wval:  7, acc: -2016, d: -128, sat: 1};
        tbl[2] = '{dval: -8, wval: -8, acc:  2304, d:  127, sat: 1};
        tbl[3] = '{dval:  5, wval:  5, acc:   900, d:  127, sat: 1};
        tbl[4] = '{dval: -1, wval:  1, acc:   -36, d:  -36, sat: 0};
        tbl[5] = '{dval:  0, wval:  3, acc:     0, d:    0, sat: 0};
        tbl[6] = '{dval:  2, wval: -3, acc:  -216, d: -128, sat: 1};
        tbl[7] = '{dval:  3, wval: -1, acc:  -108, d: -108, sat: 0};

        rst = 1'b1;
        clr = 1'b0;
        en_in = 1'b0;
        set_all(0, 0);
        step();
        step();
        cmp("reset_acc_out", int'(acc_out), 0);
        cmp("reset_d_out", int'(d_out), 0);
        cmp("reset_en_out", int'(en_out), 0);
        cmp("reset_ch_idx", int'(ch_idx), 0);
        rst = 1'b0;
        step();

        for (int t = 0; t < 8; t++) begin
            p0 = pulses;
            set_all(tbl[t].dval, tbl[t].wval);
            en_in = 1'b1;
            for (int b = 0; b < C_IN; b++) step();
            idle(3);
            exp_d = tbl[t].d;
            exp_s = tbl[t].sat;
`ifdef CONV_MAC_RELU_EN
            if (tbl[t].acc < 0) begin
                exp_d = 0;
                exp_s = 0;
            end
`endif
            cmp("tbl_pulses", pulses - p0, 1);
            cmp("tbl_acc", cap_acc, tbl[t].acc);
            cmp("tbl_d", cap_d, exp_d);
            cmp("tbl_sat", cap_sat, exp_s);
        end

        // back-to-back pixels: pulses every C_IN cycles
        p0 = pulses;
        set_all(1, 1);
        en_in = 1'b1;
        for (int b = 0; b < 3 * C_IN; b++) step();
        idle(3);
        cmp("b2b_pulses", pulses - p0, 3);

        // beats separated by random idle gaps
        p0 = pulses;
        for (int b = 0; b < 12; b++) begin
            set_all(1, 1);
            en_in = 1'b1;
            step();
            idle(int'($urandom_range(3)));
        end
        idle(3);
        cmp("gap_pulses", pulses - p0, 3);
        cmp("gap_acc", cap_acc, 36);

        // clr abandons a partial pixel
        p0 = pulses;
        set_all(5, 5);
        en_in = 1'b1;
        step();
        step();
        en_in = 1'b0;
        clr = 1'b1;
        step();
        clr = 1'b0;
        set_all(1, 1);
        en_in = 1'b1;
        for (int b = 0; b < C_IN; b++) step();
        idle(3);
        cmp("clr_pulses", pulses - p0, 1);
        cmp("clr_acc", cap_acc, 36);
        cmp("clr_ch_idx", int'(ch_idx), 0);

        // rst mid-pixel
        p0 = pulses;
        set_all(1, 1);
        en_in = 1'b1;
        for (int b = 0; b < 3; b++) step();
        rst = 1'b1;
        step();
        step();
        cmp("rst_acc_out", int'(acc_out), 0);
        cmp("rst_ch_idx", int'(ch_idx), 0);
        rst = 1'b0;
        for (int b = 0; b < C_IN; b++) step();
        idle(3);
        cmp("rst_pulses", pulses - p0, 1);
        cmp("rst_acc", cap_acc, 36);

        // randomized traffic, including clr and rst
        for (int c = 0; c < 600; c++) begin
            set_rand();
            en_in = ($urandom_range(9) < 7);
            clr   = ($urandom_range(39) == 0);
            rst   = ($urandom_range(149) == 0);
            step();
        end
        clr = 1'b0;
        rst = 1'b0;
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
